// File: rtl/div_ctrl_pkg.sv
// Shared defines for the divide controller: bus widths, funct3 codes, state encodings.
// Consumed by div_ctrl and, when DIV_CTRL_FASTPATH_EN is defined, div_fast_resolve.
package div_ctrl_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StIssue = 4'b0010,
    StWb    = 4'b0100,
    StDrain = 4'b1000
  } div_state_e;

endpackage

// File: rtl/div_fast_resolve.sv
// Combinational resolver for divide-by-zero and signed-overflow results.
// Only compiled and used when DIV_CTRL_FASTPATH_EN is defined.
`ifdef DIV_CTRL_FASTPATH_EN
module div_fast_resolve
  import div_ctrl_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [RegBus-1:0] dividend_i,
  input  logic [RegBus-1:0] divisor_i,
  output logic              special_o,
  output logic [RegBus-1:0] result_o
);

  always_comb begin
    special_o = 1'b0;
    result_o  = ZeroWord;
    if (divisor_i == ZeroWord) begin
      special_o = 1'b1;
      // op[1] selects remainder forms
      result_o  = op_i[1] ? dividend_i : '1;
    end else if (!op_i[0] && (dividend_i == 32'h8000_0000) && (divisor_i == '1)) begin
      special_o = 1'b1;
      result_o  = op_i[1] ? ZeroWord : 32'h8000_0000;
    end
  end

endmodule
`endif

// File: rtl/div_ctrl.sv
// Divide-class instruction controller between ex stage and an iterative divider.
// Optional DIV_CTRL_FASTPATH_EN resolves divide-by-zero/overflow without the divider.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid_i,
  input  logic [2:0]            op_i,
  input  logic [RegBus-1:0]     dividend_i,
  input  logic [RegBus-1:0]     divisor_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  input  logic                  flush_i,
  output logic                  div_start_o,
  output logic [RegBus-1:0]     div_dividend_o,
  output logic [RegBus-1:0]     div_divisor_o,
  output logic [2:0]            div_op_o,
  output logic [RegAddrBus-1:0] div_reg_waddr_o,
  input  logic [RegBus-1:0]     div_result_i,
  input  logic                  div_ready_i,
  input  logic                  div_busy_i,
  output logic                  hold_o,
  output logic                  reg_we_o,
  output logic [RegAddrBus-1:0] reg_waddr_o,
  output logic [RegBus-1:0]     reg_wdata_o
);

  div_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [RegBus-1:0]     dividend_q, dividend_d;
  logic [RegBus-1:0]     divisor_q, divisor_d;
  logic [RegAddrBus-1:0] waddr_q, waddr_d;
  logic [RegBus-1:0]     wdata_q, wdata_d;
  logic                  fast_special;
  logic [RegBus-1:0]     fast_result;

`ifdef DIV_CTRL_FASTPATH_EN
  div_fast_resolve u_fast_resolve (
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .special_o  (fast_special),
    .result_o   (fast_result)
  );
`else
  assign fast_special = 1'b0;
  assign fast_result  = ZeroWord;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    div_start_o = 1'b0;
    hold_o      = 1'b0;
    reg_we_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inst_valid_i && op_i[2]) begin
          hold_o     = 1'b1;
          op_d       = op_i;
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          waddr_d    = reg_waddr_i;
          if (fast_special) begin
            wdata_d = fast_result;
            state_d = StWb;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        hold_o = 1'b1;
        // Drop start on ready so the divider does not relaunch; flush beats ready.
        div_start_o = !div_ready_i && !flush_i;
        if (flush_i) begin
          state_d = StDrain;
        end else if (div_ready_i) begin
          wdata_d = div_result_i;
          state_d = StWb;
        end
      end
      StWb: begin
        reg_we_o = 1'b1;
        state_d  = StIdle;
      end
      StDrain: begin
        if (!div_busy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= 3'b000;
      dividend_q <= ZeroWord;
      divisor_q  <= ZeroWord;
      waddr_q    <= '0;
      wdata_q    <= ZeroWord;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign div_op_o        = op_q;
  assign div_dividend_o  = dividend_q;
  assign div_divisor_o   = divisor_q;
  assign div_reg_waddr_o = waddr_q;
  assign reg_waddr_o     = waddr_q;
  assign reg_wdata_o     = wdata_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: transaction-level timeline model plus RISC-V divide reference.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        inst_valid_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        div_start_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_reg_waddr_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  logic        div_busy_i;
  logic        hold_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  div_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_valid_i    (inst_valid_i),
    .op_i            (op_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .reg_waddr_i     (reg_waddr_i),
    .flush_i         (flush_i),
    .div_start_o     (div_start_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_op_o        (div_op_o),
    .div_reg_waddr_o (div_reg_waddr_o),
    .div_result_i    (div_result_i),
    .div_ready_i     (div_ready_i),
    .div_busy_i      (div_busy_i),
    .hold_o          (hold_o),
    .reg_we_o        (reg_we_o),
    .reg_waddr_o     (reg_waddr_o),
    .reg_wdata_o     (reg_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle expectations, set by the stimulus, checked at negedge.
  bit          chk_en    = 1'b0;
  logic        exp_hold  = 1'b0;
  logic        exp_start = 1'b0;
  logic        exp_we    = 1'b0;
  logic [31:0] exp_wdata = '0;
  logic [4:0]  exp_waddr = '0;
  bit          exp_issue = 1'b0;
  logic [2:0]  exp_op    = '0;
  logic [31:0] exp_a     = '0;
  logic [31:0] exp_b     = '0;
  logic [4:0]  exp_wa    = '0;

  int hold_cnt  = 0;
  int we_cnt    = 0;
  int start_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hold_o", {31'b0, hold_o}, {31'b0, exp_hold});
      chk("div_start_o", {31'b0, div_start_o}, {31'b0, exp_start});
      chk("reg_we_o", {31'b0, reg_we_o}, {31'b0, exp_we});
      if (exp_we) begin
        chk("reg_wdata_o", reg_wdata_o, exp_wdata);
        chk("reg_waddr_o", {27'b0, reg_waddr_o}, {27'b0, exp_waddr});
      end
      if (exp_issue) begin
        chk("div_op_o", {29'b0, div_op_o}, {29'b0, exp_op});
        chk("div_dividend_o", div_dividend_o, exp_a);
        chk("div_divisor_o", div_divisor_o, exp_b);
        chk("div_reg_waddr_o", {27'b0, div_reg_waddr_o}, {27'b0, exp_wa});
      end
    end
  end

  always @(negedge clk) begin
    if (hold_o) hold_cnt++;
    if (reg_we_o) we_cnt++;
    if (div_start_o) start_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // RISC-V M-extension divide semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      INST_DIV:  return ovf ? 32'h8000_0000 : 32'(sa / sb);
      INST_REM:  return ovf ? 32'h0 : 32'(sa % sb);
      INST_DIVU: return a / b;
      INST_REMU: return a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input logic h, input logic s, input logic w, input logic [31:0] wd,
                            input logic [4:0] wa, input bit iss);
    exp_hold  = h;
    exp_start = s;
    exp_we    = w;
    exp_wdata = wd;
    exp_waddr = wa;
    exp_issue = iss;
    chk_en    = 1'b1;
  endtask

  // Random divide-class request that the controller must ignore in non-IDLE states.
  task automatic junk_inputs();
    inst_valid_i = 1'($urandom);
    op_i         = 3'($urandom) | 3'b100;
    dividend_i   = $urandom;
    divisor_i    = $urandom;
    reg_waddr_i  = 5'($urandom);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      inst_valid_i = 1'($urandom);
      op_i         = 3'($urandom) & 3'b011;
      dividend_i   = $urandom;
      divisor_i    = $urandom;
      flush_i      = 1'($urandom);
      div_ready_i  = 1'b0;
      div_busy_i   = 1'b0;
      expect_cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
  endtask

  // flush_at: ISSUE cycle (1-based) carrying flush, 0 for none; drain: busy cycles after flush.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input int lat, input int flush_at,
                         input int drain);
    logic [31:0] r;
    bit          flushed;
    r       = ref_div(op, a, b);
    flushed = 1'b0;
    step();
    inst_valid_i = 1'b1;
    op_i         = op;
    dividend_i   = a;
    divisor_i    = b;
    reg_waddr_i  = wa;
    flush_i      = 1'($urandom);
    div_ready_i  = 1'b0;
    div_busy_i   = 1'b0;
    expect_cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
`ifdef DIV_CTRL_FASTPATH_EN
    if (is_special(op, a, b)) begin
      step();
      junk_inputs();
      flush_i = 1'($urandom);
      expect_cyc(1'b0, 1'b0, 1'b1, r, wa, 1'b0);
      return;
    end
`endif
    exp_op = op;
    exp_a  = a;
    exp_b  = b;
    exp_wa = wa;
    for (int i = 1; i <= lat; i++) begin
      step();
      junk_inputs();
      div_busy_i   = 1'b1;
      div_ready_i  = (i == lat);
      flush_i      = (i == flush_at);
      div_result_i = div_ready_i ? r : $urandom;
      expect_cyc(1'b1, !div_ready_i && !flush_i, 1'b0, '0, '0, 1'b1);
      if (flush_i) begin
        flushed = 1'b1;
        break;
      end
    end
    if (flushed) begin
      for (int j = 0; j <= drain; j++) begin
        step();
        junk_inputs();
        flush_i     = 1'($urandom);
        div_ready_i = 1'b0;
        div_busy_i  = (j < drain);
        expect_cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      end
    end else begin
      step();
      junk_inputs();
      flush_i     = 1'($urandom);
      div_ready_i = 1'b0;
      div_busy_i  = 1'b0;
      expect_cyc(1'b0, 1'b0, 1'b1, r, wa, 1'b0);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst hold_o", {31'b0, hold_o}, 32'h0);
    chk("rst div_start_o", {31'b0, div_start_o}, 32'h0);
    chk("rst reg_we_o", {31'b0, reg_we_o}, 32'h0);
    chk("rst reg_wdata_o", reg_wdata_o, 32'h0);
    chk("rst reg_waddr_o", {27'b0, reg_waddr_o}, 32'h0);
    chk("rst div_op_o", {29'b0, div_op_o}, 32'h0);
    chk("rst div_dividend_o", div_dividend_o, 32'h0);
    chk("rst div_divisor_o", div_divisor_o, 32'h0);
    chk("rst div_reg_waddr_o", {27'b0, div_reg_waddr_o}, 32'h0);
  endtask

  int h0, w0, s0;

  initial begin
    rst          = 1'b0;
    inst_valid_i = 1'b0;
    op_i         = '0;
    dividend_i   = '0;
    divisor_i    = '0;
    reg_waddr_i  = '0;
    flush_i      = 1'b0;
    div_result_i = '0;
    div_ready_i  = 1'b0;
    div_busy_i   = 1'b0;
    #12;
    chk_all_zero();
    #10;
    rst = 1'b1;

    // Pin the reference model.
    chk("ref divu 100/7", ref_div(INST_DIVU, 32'd100, 32'd7), 32'd14);
    chk("ref rem -7/2", ref_div(INST_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("ref div x/0", ref_div(INST_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("ref remu x/0", ref_div(INST_REMU, 32'd5, 32'd0), 32'd5);
    chk("ref div ovf", ref_div(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("ref rem ovf", ref_div(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    gap(2);

    // DIVU 100/7 with a 34-cycle divider.
    h0 = hold_cnt; w0 = we_cnt; s0 = start_cnt;
    run_div(INST_DIVU, 32'd100, 32'd7, 5'd3, 34, 0, 0);
    gap(1);
    chk("divu hold cycles", 32'(hold_cnt - h0), 32'd35);
    chk("divu we pulses", 32'(we_cnt - w0), 32'd1);
    chk("divu start cycles", 32'(start_cnt - s0), 32'd33);

    // REM -7/2: start held for every non-ready ISSUE cycle.
    s0 = start_cnt;
    run_div(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 5, 0, 0);
    gap(1);
    chk("rem start cycles", 32'(start_cnt - s0), 32'd4);

    // Flush 10 cycles into ISSUE, then drain.
    w0 = we_cnt; s0 = start_cnt;
    run_div(INST_DIV, 32'd1000, 32'd7, 5'd4, 20, 10, 3);
    gap(1);
    chk("flush no write", 32'(we_cnt - w0), 32'd0);
    chk("flush start cycles", 32'(start_cnt - s0), 32'd9);

    // Ready and flush together: flush wins.
    w0 = we_cnt;
    run_div(INST_DIVU, 32'd50, 32'd5, 5'd6, 6, 6, 0);
    gap(1);
    chk("ready+flush no write", 32'(we_cnt - w0), 32'd0);

    // Special cases: latency 2 with fastpath, otherwise through the divider.
    s0 = start_cnt;
    run_div(INST_DIV, 32'd123, 32'd0, 5'd7, 4, 0, 0);
    run_div(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 4, 0, 0);
    gap(1);
`ifdef DIV_CTRL_FASTPATH_EN
    chk("fastpath no start", 32'(start_cnt - s0), 32'd0);
`else
    chk("special via divider start", 32'(start_cnt - s0), 32'd6);
`endif

    // Reset pulse mid-ISSUE.
    step();
    inst_valid_i = 1'b1;
    op_i         = INST_DIVU;
    dividend_i   = 32'd1000;
    divisor_i    = 32'd3;
    reg_waddr_i  = 5'd11;
    flush_i      = 1'b0;
    expect_cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    exp_op = INST_DIVU; exp_a = 32'd1000; exp_b = 32'd3; exp_wa = 5'd11;
    for (int i = 0; i < 4; i++) begin
      step();
      inst_valid_i = 1'b0;
      div_busy_i   = 1'b1;
      div_ready_i  = 1'b0;
      expect_cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    end
    #2;
    chk_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk_all_zero();
    div_busy_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    w0  = we_cnt;
    gap(3);
    run_div(INST_DIVU, 32'd9, 32'd3, 5'd12, 4, 0, 0);
    gap(1);
    chk("post-reset single write", 32'(we_cnt - w0), 32'd1);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      int          fl;
      int          r;
      op  = 3'b100 | 3'($urandom);
      a   = $urandom;
      b   = $urandom;
      r   = $urandom_range(0, 5);
      if (r == 0) b = 0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) begin a = $urandom_range(0, 999); b = $urandom_range(1, 20); end
      lat = $urandom_range(1, 6);
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      run_div(op, a, b, 5'($urandom), lat, fl, $urandom_range(0, 2));
      gap($urandom_range(0, 2));
    end
    gap(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameters SHALL be none; all widths SHALL use the shared RegBus (32) and RegAddrBus (5) constants.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserted = 0.
REQ-004 inst_valid_i  input  1  ex stage presents a divide-class instruction this cycle.
REQ-005 op_i  input  3  funct3: DIV=100, DIVU=101, REM=110, REMU=111.
REQ-006 dividend_i, divisor_i  input  32 each  rs1 and rs2 operand values.
REQ-007 reg_waddr_i  input  5  destination register.
REQ-008 flush_i  input  1  pipeline kill (jump or interrupt); the in-flight divide SHALL be discarded.
REQ-009 div_start_o  output  1  start to the divider; SHALL be held high for the whole operation.
REQ-010 div_dividend_o, div_divisor_o  output  32 each; div_op_o  output  3; div_reg_waddr_o  output  5  latched request fields.
REQ-011 div_result_i  input  32; div_ready_i  input  1; div_busy_i  input  1  divider responses.
REQ-012 hold_o  output  1  pipeline stall request.
REQ-013 reg_we_o  output  1; reg_waddr_o  output  5; reg_wdata_o  output  32  register-file writeback.

Function
REQ-014 States SHALL be IDLE, ISSUE, WB and DRAIN, one-hot encoded.
REQ-015 In IDLE, when inst_valid_i=1 and op_i[2]=1, the block SHALL latch op, operands and waddr, drive hold_o=1 combinationally in that cycle, and go to ISSUE.
REQ-016 In ISSUE, div_start_o SHALL be 1 and hold_o SHALL be 1.
REQ-017 div_start_o SHALL be gated low combinationally when div_ready_i=1, so the divider does not re-launch from its idle state.
REQ-018 In ISSUE with div_ready_i=1 and flush_i=0, the block SHALL capture div_result_i into reg_wdata_o and go to WB.
REQ-019 In WB, for exactly 1 cycle, reg_we_o SHALL be 1 with the latched waddr, hold_o SHALL be 0, and the next state SHALL be IDLE.
REQ-020 New requests SHALL be accepted only in IDLE, so back-to-back divides are separated by the WB cycle.
REQ-021 flush_i=1 in ISSUE SHALL drop div_start_o in the same cycle, suppress any writeback, and go to DRAIN.
REQ-022 Flush coinciding with div_ready_i SHALL win: no write.
REQ-023 DRAIN SHALL hold div_start_o=0 and hold_o=0, and SHALL return to IDLE once div_busy_i=0.
REQ-024 flush_i in IDLE or WB SHALL have no effect; a WB already in progress SHALL complete.
REQ-025 Total latency SHALL be divider latency + 2 cycles (accept cycle + WB).

Reset
REQ-026 On rst=0, state SHALL be IDLE and every output SHALL be 0, including hold_o, div_start_o and reg_we_o.
REQ-027 Reset asserted mid-operation SHALL abort immediately without writeback.
REQ-028 Reset deassertion SHALL be synchronised externally.

Configuration
REQ-029 With DIV_CTRL_FASTPATH_EN defined, special cases SHALL be resolved in IDLE without starting the divider, and the block SHALL go directly to WB (latency 2):
- divisor==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
- signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-030 Without DIV_CTRL_FASTPATH_EN, every divide SHALL go through ISSUE.

Structure
REQ-031 The INST_DIV/DIVU/REM/REMU codes, the state encodings and the ZeroWord constant SHALL live in the shared defines package.
REQ-032 The special-case resolver SHALL be one combinational sub-module, div_fast_resolve, instantiated only under DIV_CTRL_FASTPATH_EN.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- DIVU 100/7, model ready after 34 cycles -> single reg_we_o pulse, wdata 14; hold_o high 35 cycles; div_start_o low on the ready cycle.
- REM -7/2 -> wdata 0xFFFFFFFF (-1); the divider sees start held continuously.
- Flush 10 cycles into ISSUE -> div_start_o drops that cycle, no write, DRAIN until busy=0, then IDLE.
- Ready and flush in the same cycle -> reg_we_o stays 0.
- FASTPATH on: DIV x/0 -> wdata 0xFFFFFFFF at latency 2, div_start_o never high; DIV 0x80000000/-1 -> 0x80000000.
- Reset pulse mid-ISSUE -> all outputs 0 asynchronously; a following DIVU 9/3 completes with 3.
